// File: rtl/apb_i2c_csr.sv
// ---------------------------------------------------------------------------
// apb_i2c_csr
//   APB3 control/status register block for the I2C master. Connects the APB
//   bus to the I2C core and its TX/RX FIFOs. Registers are 8 bits wide. The
//   APB data bus may be 8, 16 or 32 bits wide: upper read bits return 0 and
//   upper write bits are ignored.
//
//   Register map:
//     0x00 TXDATA   RW   a successful write pushes into the TX-FIFO
//     0x01 RXDATA   RO   a successful read pops the RX-FIFO
//     0x02 STATUS   RO   fifo_status_i
//     0x03 SADDR    RW
//     0x04 CMD      RW   bit6 START is cleared by start_done_i,
//                        bit7 RST_DONE is set by reset_done_i
//     0x05 PRESCALE RW
//     0x06 IRQ_STAT W1C  event_i sets a bit, writing 1 clears it
//     0x07 IRQ_EN   RW
//
// Ports:
//   pclk_i, preset_ni      clock, asynchronous active-low reset
//   paddr_i .. pslverr_o   APB3 slave port
//   tx_data_o, tx_push_o   TXDATA register and 1-cycle TX-FIFO push
//   tx_full_i              TX-FIFO full
//   rx_data_i, rx_pop_o    RX-FIFO head and 1-cycle pop
//   rx_empty_i             RX-FIFO empty
//   fifo_status_i          FIFO status, returned by STATUS reads
//   start_done_i           core accepted START (clears CMD[6])
//   reset_done_i           core finished soft reset (sets CMD[7])
//   event_i                1-cycle interrupt event pulses
//   reg_*_o                SADDR / CMD / PRESCALE registers
//   irq_o                  registered |(IRQ_STAT & IRQ_EN)
//
// Handshake: a transfer completes in the cycle where psel_i, penable_i and
// pready_o are all 1. Only in that cycle is write data committed and are
// prdata_o and pslverr_o valid. Outside that cycle, both of those outputs
// are 0. pready_o is 1 whenever no transfer is being stretched.
// ---------------------------------------------------------------------------
module apb_i2c_csr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_WAIT    = 1,
  parameter int NUM_IRQ    = 4
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_push_o,
  input  logic                  tx_full_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_pop_o,
  input  logic                  rx_empty_i,
  input  logic [7:0]            fifo_status_i,
  input  logic                  start_done_i,
  input  logic                  reset_done_i,
  input  logic [NUM_IRQ-1:0]    event_i,
  output logic [7:0]            reg_slave_address_o,
  output logic [7:0]            reg_command_o,
  output logic [7:0]            reg_prescale_o,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] A_TXDATA   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_RXDATA   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_SADDR    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_CMD      = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_STAT = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN   = ADDR_WIDTH'(7);
  localparam logic [2:0]            WAIT_LAST  = 3'(RD_WAIT);
  localparam bit                    HAS_WAIT   = (RD_WAIT > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;

  logic [7:0] tx_data_q;
  logic       tx_push_q;
  logic [7:0] saddr_q;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] prescale_q;
  logic [7:0] irq_stat_q, irq_stat_d;
  logic [7:0] irq_en_q;
  logic       irq_q;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic is_txdata, is_rxdata, is_status, is_saddr;
  logic is_cmd, is_prescale, is_irq_stat, is_irq_en, is_mapped;
  logic rx_read, rx_read_ok, need_wait;

  assign is_txdata   = (paddr_i == A_TXDATA);
  assign is_rxdata   = (paddr_i == A_RXDATA);
  assign is_status   = (paddr_i == A_STATUS);
  assign is_saddr    = (paddr_i == A_SADDR);
  assign is_cmd      = (paddr_i == A_CMD);
  assign is_prescale = (paddr_i == A_PRESCALE);
  assign is_irq_stat = (paddr_i == A_IRQ_STAT);
  assign is_irq_en   = (paddr_i == A_IRQ_EN);
  assign is_mapped   = (paddr_i <= A_IRQ_EN);

  assign rx_read    = is_rxdata & ~pwrite_i;
  assign rx_read_ok = rx_read & ~rx_empty_i;
  assign need_wait  = rx_read_ok & HAS_WAIT;

  // ---------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // wait_cnt counts the low-pready cycles already spent. The first access
  // cycle is one of them, so the counter enters WAIT at 1.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready_o   = 1'b1;
    rx_pop_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = 3'd0;
        if (psel_i && !penable_i) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (penable_i) begin
          rx_pop_o = rx_read_ok;
          if (need_wait) begin
            pready_o   = 1'b0;
            state_d    = ST_WAIT;
            wait_cnt_d = 3'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT: begin
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          pready_o   = 1'b0;
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Completion, error and read data
  // ---------------------------------------------------------------------
  logic complete, access_err, wr_en;
  logic [7:0] rd_mux;

  assign complete = psel_i & penable_i & pready_o & (state_q != ST_IDLE);

  // An RXDATA read that reached WAIT was already checked for an empty FIFO
  // when it popped. The pop itself may have emptied the FIFO, so the flag
  // is not sampled again.
  always_comb begin
    access_err = 1'b0;
    if (state_q != ST_WAIT) begin
      access_err = ~is_mapped
                 | (pwrite_i & (is_rxdata | is_status))
                 | (rx_read & rx_empty_i)
                 | (pwrite_i & is_txdata & tx_full_i);
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (1'b1)
      is_txdata:   rd_mux = tx_data_q;
      is_rxdata:   rd_mux = rx_data_i;
      is_status:   rd_mux = fifo_status_i;
      is_saddr:    rd_mux = saddr_q;
      is_cmd:      rd_mux = cmd_q;
      is_prescale: rd_mux = prescale_q;
      is_irq_stat: rd_mux = irq_stat_q;
      is_irq_en:   rd_mux = irq_en_q;
      default:     rd_mux = 8'h00;
    endcase
  end

  assign pslverr_o = complete & access_err;
  assign prdata_o  = (complete && !pwrite_i && !access_err) ? DATA_WIDTH'(rd_mux)
                                                           : '0;
  assign wr_en     = complete & pwrite_i & ~access_err;

  if (DATA_WIDTH > 8) begin : g_wide
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^pwdata_i[DATA_WIDTH-1:8];
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [7:0] wdata8;
  logic [7:0] evt_ext;
  logic [7:0] w1c_mask;

  assign wdata8 = pwdata_i[7:0];

  always_comb begin
    evt_ext              = 8'h00;
    evt_ext[NUM_IRQ-1:0] = event_i;
  end

  // Set wins over a same-cycle W1C because the set is ORed in last.
  assign w1c_mask   = (wr_en && is_irq_stat) ? wdata8 : 8'h00;
  assign irq_stat_d = (irq_stat_q & ~w1c_mask) | evt_ext;

  // Hardware updates first, so a same-cycle APB write takes priority.
  always_comb begin
    cmd_d = cmd_q;
    if (start_done_i) cmd_d[6] = 1'b0;
    if (reset_done_i) cmd_d[7] = 1'b1;
    if (wr_en && is_cmd) cmd_d = wdata8;
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      tx_data_q  <= 8'h00;
      tx_push_q  <= 1'b0;
      saddr_q    <= 8'h00;
      cmd_q      <= 8'h00;
      prescale_q <= 8'h00;
      irq_stat_q <= 8'h00;
      irq_en_q   <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      tx_push_q  <= wr_en & is_txdata;
      if (wr_en && is_txdata)   tx_data_q  <= wdata8;
      if (wr_en && is_saddr)    saddr_q    <= wdata8;
      if (wr_en && is_prescale) prescale_q <= wdata8;
      if (wr_en && is_irq_en)   irq_en_q   <= wdata8;
      cmd_q      <= cmd_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign tx_data_o           = tx_data_q;
  assign tx_push_o           = tx_push_q;
  assign reg_slave_address_o = saddr_q;
  assign reg_command_o       = cmd_q;
  assign reg_prescale_o      = prescale_q;
  assign irq_o               = irq_q;

endmodule

// File: tb/tb_apb_i2c_csr.sv
module tb_apb_i2c_csr;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 2;
  localparam int NI = 4;

  // ---------------- clock / reset ----------------
  logic          pclk_i = 1'b0;
  logic          preset_ni = 1'b0;
  logic [AW-1:0] paddr_i = '0;
  logic          psel_i = 1'b0;
  logic          penable_i = 1'b0;
  logic          pwrite_i = 1'b0;
  logic [DW-1:0] pwdata_i = '0;
  logic [DW-1:0] prdata_o;
  logic          pready_o;
  logic          pslverr_o;
  logic [7:0]    tx_data_o;
  logic          tx_push_o;
  logic          tx_full_i = 1'b0;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_pop_o;
  logic          rx_empty_i = 1'b0;
  logic [7:0]    fifo_status_i = 8'h00;
  logic          start_done_i = 1'b0;
  logic          reset_done_i = 1'b0;
  logic [NI-1:0] event_i = '0;
  logic [7:0]    reg_slave_address_o;
  logic [7:0]    reg_command_o;
  logic [7:0]    reg_prescale_o;
  logic          irq_o;

  always #5 pclk_i = ~pclk_i;

  apb_i2c_csr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WAIT(RW), .NUM_IRQ(NI)
  ) dut (
    .pclk_i(pclk_i), .preset_ni(preset_ni),
    .paddr_i(paddr_i), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o),
    .tx_data_o(tx_data_o), .tx_push_o(tx_push_o), .tx_full_i(tx_full_i),
    .rx_data_i(rx_data_i), .rx_pop_o(rx_pop_o), .rx_empty_i(rx_empty_i),
    .fifo_status_i(fifo_status_i), .start_done_i(start_done_i),
    .reset_done_i(reset_done_i), .event_i(event_i),
    .reg_slave_address_o(reg_slave_address_o), .reg_command_o(reg_command_o),
    .reg_prescale_o(reg_prescale_o), .irq_o(irq_o)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int push_cnt = 0;

  // Inputs change 1 time unit after posedge, so negedge sampling is race-free.
  always @(negedge pclk_i) begin
    if (rx_pop_o)  pop_cnt++;
    if (tx_push_o) push_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apb(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = '0;
    er    = 1'b0;
    @(posedge pclk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr; pwdata_i = wd;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk_i);
      if (pready_o) begin
        done = 1'b1;
        rd   = prdata_o;
        er   = pslverr_o;
      end else begin
        waits++;
      end
    end
    if (!done) check("pready_timeout", 32'(done), 32'd1);
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic pulse_event(input logic [NI-1:0] e);
    @(posedge pclk_i); #1; event_i = e;
    @(posedge pclk_i); #1; event_i = '0;
  endtask

  task automatic do_reset();
    preset_ni = 1'b0;
    repeat (2) @(posedge pclk_i);
    #1 preset_ni = 1'b1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_tx, m_saddr, m_cmd, m_pre, m_stat, m_en;

  // ---------------- test sequence ----------------
  logic [31:0] rd;
  logic        er;
  int          waits;
  int          pop0, push0;

  initial begin
    do_reset();

    // Reset state.
    check("rst_pready", 32'(pready_o), 32'd1);
    check("rst_prdata", prdata_o, 32'd0);
    check("rst_pslverr", 32'(pslverr_o), 32'd0);
    check("rst_tx_push", 32'(tx_push_o), 32'd0);
    check("rst_rx_pop", 32'(rx_pop_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_cmd", 32'(reg_command_o), 32'd0);

    // Every mapped address reads 0 without error; 0x08 is unmapped.
    for (int a = 0; a < 8; a++) begin
      apb(8'(a), 1'b0, 32'd0, rd, er, waits);
      check($sformatf("rd0_data_%0d", a), rd, 32'd0);
      check($sformatf("rd0_err_%0d", a), 32'(er), 32'd0);
    end
    apb(8'h08, 1'b0, 32'd0, rd, er, waits);
    check("unmapped_err", 32'(er), 32'd1);
    check("unmapped_data", rd, 32'd0);
    apb(8'h02, 1'b1, 32'h55, rd, er, waits);
    check("wr_status_err", 32'(er), 32'd1);

    // PRESCALE write/read with upper write bits ignored.
    apb(8'h05, 1'b1, 32'hFFFF_FFA5, rd, er, waits);
    check("pre_wr_err", 32'(er), 32'd0);
    apb(8'h05, 1'b0, 32'd0, rd, er, waits);
    check("pre_rd", rd, 32'h0000_00A5);
    check("pre_out", 32'(reg_prescale_o), 32'hA5);

    // RXDATA read with wait states.
    rx_data_i = 8'h3C; rx_empty_i = 1'b0;
    pop0 = pop_cnt;
    apb(8'h01, 1'b0, 32'd0, rd, er, waits);
    check("rx_waits", 32'(waits), 32'(RW));
    check("rx_data", rd, 32'h3C);
    check("rx_err", 32'(er), 32'd0);
    check("rx_pops", 32'(pop_cnt - pop0), 32'd1);
    rx_empty_i = 1'b1;
    pop0 = pop_cnt;
    apb(8'h01, 1'b0, 32'd0, rd, er, waits);
    check("rx_empty_err", 32'(er), 32'd1);
    check("rx_empty_data", rd, 32'd0);
    check("rx_empty_waits", 32'(waits), 32'd0);
    check("rx_empty_pops", 32'(pop_cnt - pop0), 32'd0);
    rx_empty_i = 1'b0;

    // TXDATA write against a full and a non-full FIFO.
    tx_full_i = 1'b1;
    push0 = push_cnt;
    apb(8'h00, 1'b1, 32'h11, rd, er, waits);
    check("tx_full_err", 32'(er), 32'd1);
    check("tx_full_push", 32'(tx_push_o), 32'd0);
    check("tx_full_data", 32'(tx_data_o), 32'd0);
    tx_full_i = 1'b0;
    apb(8'h00, 1'b1, 32'h11, rd, er, waits);
    check("tx_err", 32'(er), 32'd0);
    check("tx_push", 32'(tx_push_o), 32'd1);
    check("tx_data", 32'(tx_data_o), 32'h11);
    @(posedge pclk_i); #1;
    check("tx_push_1cyc", 32'(tx_push_o), 32'd0);
    check("tx_push_cnt", 32'(push_cnt - push0), 32'd1);

    // Interrupts.
    apb(8'h07, 1'b1, 32'h01, rd, er, waits);
    pulse_event(4'b0001);
    check("irq_lag", 32'(irq_o), 32'd0);
    @(posedge pclk_i); #1;
    check("irq_set", 32'(irq_o), 32'd1);
    event_i = 4'b0001;
    apb(8'h06, 1'b1, 32'h01, rd, er, waits);
    event_i = '0;
    apb(8'h06, 1'b0, 32'd0, rd, er, waits);
    check("w1c_set_wins", rd, 32'h01);
    apb(8'h06, 1'b1, 32'hFF, rd, er, waits);
    check("irq_still_hi", 32'(irq_o), 32'd1);
    @(posedge pclk_i); #1;
    check("irq_cleared", 32'(irq_o), 32'd0);
    apb(8'h06, 1'b0, 32'd0, rd, er, waits);
    check("stat_cleared", rd, 32'h00);

    // CMD hardware set/clear and write priority.
    apb(8'h04, 1'b1, 32'h40, rd, er, waits);
    check("cmd_wr", 32'(reg_command_o), 32'h40);
    @(posedge pclk_i); #1; start_done_i = 1'b1;
    @(posedge pclk_i); #1; start_done_i = 1'b0;
    check("cmd_start_clr", 32'(reg_command_o), 32'h00);
    @(posedge pclk_i); #1; reset_done_i = 1'b1;
    @(posedge pclk_i); #1; reset_done_i = 1'b0;
    check("cmd_rst_done", 32'(reg_command_o), 32'h80);
    reset_done_i = 1'b1;
    apb(8'h04, 1'b1, 32'h05, rd, er, waits);
    reset_done_i = 1'b0;
    check("cmd_apb_wins", 32'(reg_command_o), 32'h05);

    // Reset in the middle of an RXDATA wait: no further pop, everything cleared.
    apb(8'h07, 1'b1, 32'h0F, rd, er, waits);
    pulse_event(4'b0010);
    @(posedge pclk_i); #1;
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    rx_data_i = 8'h77;
    pop0 = pop_cnt;
    @(posedge pclk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 8'h01; pwrite_i = 1'b0;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    @(negedge pclk_i);
    check("mid_pop", 32'(rx_pop_o), 32'd1);
    check("mid_pready", 32'(pready_o), 32'd0);
    @(posedge pclk_i); #1;
    preset_ni = 1'b0;
    #1;
    check("mid_rst_pop", 32'(rx_pop_o), 32'd0);
    check("mid_rst_prdata", prdata_o, 32'd0);
    check("mid_rst_pslverr", 32'(pslverr_o), 32'd0);
    check("mid_rst_irq", 32'(irq_o), 32'd0);
    check("mid_rst_regs", {tx_data_o, reg_slave_address_o, reg_command_o, reg_prescale_o},
          32'd0);
    check("mid_rst_push", 32'(tx_push_o), 32'd0);
    repeat (2) @(posedge pclk_i);
    #1;
    check("mid_rst_pop_cnt", 32'(pop_cnt - pop0), 32'd1);
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge pclk_i); #1;
    preset_ni = 1'b1;

    // Randomized traffic against the model.
    m_tx = 8'h00; m_saddr = 8'h00; m_cmd = 8'h00;
    m_pre = 8'h00; m_stat = 8'h00; m_en = 8'h00;
    for (int it = 0; it < 60; it++) begin
      logic [7:0]  addr;
      logic        wr, exp_err, exp_push;
      logic [31:0] wd, exp_rd;
      logic [NI-1:0] ev;
      int          r, exp_waits, exp_pops;
      if ($urandom_range(0, 2) == 0) begin
        ev = NI'($urandom);
        pulse_event(ev);
        m_stat = m_stat | 8'(ev);
      end
      r    = $urandom_range(0, 9);
      addr = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      tx_full_i     = ($urandom_range(0, 3) == 0);
      rx_empty_i    = ($urandom_range(0, 3) == 0);
      rx_data_i     = 8'($urandom);
      fifo_status_i = 8'($urandom);

      exp_err = 1'b0; exp_rd = 32'd0; exp_push = 1'b0; exp_waits = 0; exp_pops = 0;
      if (wr) begin
        case (addr)
          8'h00: if (tx_full_i) exp_err = 1'b1; else begin m_tx = wd[7:0]; exp_push = 1'b1; end
          8'h03: m_saddr = wd[7:0];
          8'h04: m_cmd   = wd[7:0];
          8'h05: m_pre   = wd[7:0];
          8'h06: m_stat  = m_stat & ~wd[7:0];
          8'h07: m_en    = wd[7:0];
          default: exp_err = 1'b1;
        endcase
      end else begin
        case (addr)
          8'h00: exp_rd = 32'(m_tx);
          8'h01: if (rx_empty_i) exp_err = 1'b1;
                 else begin exp_rd = 32'(rx_data_i); exp_waits = RW; exp_pops = 1; end
          8'h02: exp_rd = 32'(fifo_status_i);
          8'h03: exp_rd = 32'(m_saddr);
          8'h04: exp_rd = 32'(m_cmd);
          8'h05: exp_rd = 32'(m_pre);
          8'h06: exp_rd = 32'(m_stat);
          8'h07: exp_rd = 32'(m_en);
          default: exp_err = 1'b1;
        endcase
      end

      pop0 = pop_cnt;
      apb(addr, wr, wd, rd, er, waits);
      check($sformatf("rnd%0d_a%0h_w%0d_rd", it, addr, wr), rd, exp_rd);
      check($sformatf("rnd%0d_err", it), 32'(er), 32'(exp_err));
      check($sformatf("rnd%0d_waits", it), 32'(waits), 32'(exp_waits));
      check($sformatf("rnd%0d_push", it), 32'(tx_push_o), 32'(exp_push));
      @(posedge pclk_i); #1;
      check($sformatf("rnd%0d_pops", it), 32'(pop_cnt - pop0), 32'(exp_pops));
      check($sformatf("rnd%0d_irq", it), 32'(irq_o), 32'(|(m_stat & m_en)));
      check($sformatf("rnd%0d_regs", it),
            {tx_data_o, reg_slave_address_o, reg_command_o, reg_prescale_o},
            {m_tx, m_saddr, m_cmd, m_pre});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
